// File: rtl/cla_pipe_adder_pkg.sv
// cla_pipe_pkg
//   Shared constants, helpers and types for the pipelined carry-lookahead
//   adder (cla_pipe_adder) and its 4-bit lookahead group (cla4_grp).
//
//   GRP_W      : width of one lookahead group (4 bits)
//   nstg()     : number of pipeline stages for a given WIDTH / GRP_PER_STG
//   stg_ctl_t  : fixed-width control part of one pipeline stage register
//
// The data part of a stage (resolved low sum bits and unresolved high a/b
// bits) is sized by the WIDTH parameter of the top, so it lives next to the
// control struct as per-stage arrays inside cla_pipe_adder.
package cla_pipe_pkg;

  localparam int GRP_W = 4;

  // Stage count: each stage resolves GRP_PER_STG groups of GRP_W bits.
  function automatic int nstg(input int width, input int grpPerStg);
    return width / (GRP_W * grpPerStg);
  endfunction

  // valid : stage holds a live operation (cleared for bubbles)
  // carry : carry out of the highest bit resolved so far
  // sub   : operation is a subtract (b is inverted group by group)
  typedef struct packed {
    logic valid;
    logic carry;
    logic sub;
  } stg_ctl_t;

endpackage

// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if
//   Operand/result handshake bundle for cla_pipe_adder.
//
//   Input side : in_valid, in_ready, a, b, c0 (and sub when CLA_PIPE_SUB_EN)
//   Output side: out_valid, out_ready, sum, cout, ovf
//
//   modport master : operand issue / result writeback side
//   modport slave  : the adder itself
//
// Optional feature macro: CLA_PIPE_SUB_EN adds the 1-bit 'sub' operand flag.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c0;
`ifdef CLA_PIPE_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef CLA_PIPE_SUB_EN
  modport master (
    output in_valid, a, b, c0, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, c0, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, c0, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, c0, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif

endinterface

// File: rtl/cla_pipe_adder_cla4_grp.sv
// cla4_grp
//   Combinational 4-bit carry-lookahead group.
//
//   a_i, b_i : group operand bits
//   cin_i    : carry into bit 0 of the group
//   sum_o    : group sum bits
//   gp_o     : group propagate (all four bits propagate)
//   gg_o     : group generate (independent of cin_i)
//   c3_o     : carry into bit 3, used for signed overflow on the MSB group
module cla4_grp
  import cla_pipe_pkg::*;
(
  input  logic [GRP_W-1:0] a_i,
  input  logic [GRP_W-1:0] b_i,
  input  logic             cin_i,
  output logic [GRP_W-1:0] sum_o,
  output logic             gp_o,
  output logic             gg_o,
  output logic             c3_o
);

  logic [GRP_W-1:0] p;
  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Every internal carry is a flat sum of products of cin_i and the bit
  // p/g terms, so no carry waits on a lower one.
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin_i);

  assign sum_o = p ^ c;
  assign c3_o  = c[3];

  // Group P/G deliberately exclude cin_i so the stage-level lookahead can
  // combine groups without a combinational path through this carry.
  assign gp_o = &p;
  assign gg_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined, parametrised carry-lookahead adder. A WIDTH-bit add is split
//   into 4-bit lookahead groups; each of the NSTG pipeline stages resolves
//   GRP_PER_STG groups and hands its carry to the next stage in a register.
//   One operation per clock, NSTG cycles latency, full backpressure.
//
//   Parameters
//     WIDTH       : operand/sum width, a multiple of 4*GRP_PER_STG
//     GRP_PER_STG : 4-bit groups resolved per stage
//
//   Ports
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset
//     bus   : cla_pipe_adder_if.slave
//             in_valid/in_ready/a/b/c0[/sub] in, out_valid/out_ready/
//             sum/cout/ovf out
//
//   Optional feature macro: CLA_PIPE_SUB_EN
//     Defined  : bus.sub=1 computes a-b (b inverted, carry-in forced to 1).
//     Undefined: add only, sub is tied low internally.
module cla_pipe_adder
  import cla_pipe_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int GRP_PER_STG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  cla_pipe_adder_if.slave  bus
);

  localparam int NSTG = nstg(WIDTH, GRP_PER_STG);
  localparam int NGRP = WIDTH / GRP_W;

  // Stage registers: control struct plus data. a_q/b_q are stored full
  // width for simple indexing; the already-resolved low bits are never read
  // again, so synthesis keeps only the unresolved high part.
  stg_ctl_t         ctl_q [NSTG];
  logic [WIDTH-1:0] sum_q [NSTG];
  logic [WIDTH-1:0] a_q   [NSTG];
  logic [WIDTH-1:0] b_q   [NSTG];
  logic             cmsb_q;

  logic             adv;
  logic             subIn;

  // Operands as seen by each stage (stage 0 from the bus, others from the
  // previous stage register).
  logic             stgValid [NSTG];
  logic             stgSub   [NSTG];
  logic             stgCin   [NSTG];
  logic             stgCout  [NSTG];
  logic [WIDTH-1:0] stgA     [NSTG];
  logic [WIDTH-1:0] stgB     [NSTG];
  logic [WIDTH-1:0] stgSum   [NSTG];
  logic [WIDTH-1:0] sum_d    [NSTG];

  wire  [NGRP-1:0]  grpP;
  wire  [NGRP-1:0]  grpG;
  logic [NGRP-1:0]  grpC;
  wire  [GRP_W-1:0] grpSum [NGRP];
  wire              grpC3  [NGRP];

`ifdef CLA_PIPE_SUB_EN
  assign subIn = bus.sub;
`else
  assign subIn = 1'b0;
`endif

  // Whole pipe moves together: it may shift whenever the output slot is
  // empty or being consumed this cycle.
  assign adv          = ~ctl_q[NSTG-1].valid | bus.out_ready;
  assign bus.in_ready = adv;

  // Carry into group n of a stage by full lookahead over the stage's group
  // P/G terms: cin & P[n-1..0] | G[m] & P[n-1..m+1] for every m < n.
  function automatic logic carryInto(
    input logic                   cin,
    input logic [GRP_PER_STG-1:0] p,
    input logic [GRP_PER_STG-1:0] g,
    input int                     n
  );
    logic c;
    logic t;
    c = cin;
    for (int m = 0; m < GRP_PER_STG; m++) begin
      if (m < n) c = c & p[m];
    end
    for (int m = 0; m < GRP_PER_STG; m++) begin
      if (m < n) begin
        t = g[m];
        for (int q = 0; q < GRP_PER_STG; q++) begin
          if (q > m && q < n) t = t & p[q];
        end
        c = c | t;
      end
    end
    return c;
  endfunction

  // Stage inputs. Subtract forces carry-in to 1 regardless of c0.
  always_comb begin
    stgValid[0] = bus.in_valid;
    stgSub[0]   = subIn;
    stgCin[0]   = subIn | bus.c0;
    stgA[0]     = bus.a;
    stgB[0]     = bus.b;
    stgSum[0]   = '0;
    for (int k = 1; k < NSTG; k++) begin
      stgValid[k] = ctl_q[k-1].valid;
      stgSub[k]   = ctl_q[k-1].sub;
      stgCin[k]   = ctl_q[k-1].carry;
      stgA[k]     = a_q[k-1];
      stgB[k]     = b_q[k-1];
      stgSum[k]   = sum_q[k-1];
    end
  end

  // One lookahead group per 4 bits; each group belongs to stage j/GRP_PER_STG
  // and inverts b itself using that stage's carried sub flag.
  for (genvar j = 0; j < NGRP; j++) begin : g_grp
    localparam int K = j / GRP_PER_STG;
    wire [GRP_W-1:0] bEff;

    assign bEff = stgB[K][j*GRP_W +: GRP_W] ^ {GRP_W{stgSub[K]}};

    cla4_grp u_grp (
      .a_i   (stgA[K][j*GRP_W +: GRP_W]),
      .b_i   (bEff),
      .cin_i (grpC[j]),
      .sum_o (grpSum[j]),
      .gp_o  (grpP[j]),
      .gg_o  (grpG[j]),
      .c3_o  (grpC3[j])
    );
  end

  // Group carries and stage carry-out, all in parallel from the stage's
  // incoming carry.
  always_comb begin
    grpC = '0;
    for (int k = 0; k < NSTG; k++) begin
      for (int g = 0; g < GRP_PER_STG; g++) begin
        grpC[k*GRP_PER_STG + g] = carryInto(stgCin[k],
                                            grpP[k*GRP_PER_STG +: GRP_PER_STG],
                                            grpG[k*GRP_PER_STG +: GRP_PER_STG],
                                            g);
      end
      stgCout[k] = carryInto(stgCin[k],
                             grpP[k*GRP_PER_STG +: GRP_PER_STG],
                             grpG[k*GRP_PER_STG +: GRP_PER_STG],
                             GRP_PER_STG);
    end
  end

  // Each stage appends its freshly resolved groups to the sum so far.
  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      sum_d[k] = stgSum[k];
      for (int g = 0; g < GRP_PER_STG; g++) begin
        sum_d[k][(k*GRP_PER_STG + g)*GRP_W +: GRP_W] = grpSum[k*GRP_PER_STG + g];
      end
    end
  end

  // Valid bits always shift on adv so bubbles travel; data only loads for
  // live operations, which keeps the result registers quiet across bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTG; k++) begin
        ctl_q[k] <= '0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
      cmsb_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NSTG; k++) begin
        ctl_q[k].valid <= stgValid[k];
        if (stgValid[k]) begin
          ctl_q[k].carry <= stgCout[k];
          ctl_q[k].sub   <= stgSub[k];
          sum_q[k]       <= sum_d[k];
          a_q[k]         <= stgA[k];
          b_q[k]         <= stgB[k];
        end
      end
      if (stgValid[NSTG-1]) begin
        cmsb_q <= grpC3[NGRP-1];
      end
    end
  end

  assign bus.out_valid = ctl_q[NSTG-1].valid;
  assign bus.sum       = sum_q[NSTG-1];
  assign bus.cout      = ctl_q[NSTG-1].carry;
  assign bus.ovf       = cmsb_q ^ ctl_q[NSTG-1].carry;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder
//   Self-checking bench for cla_pipe_adder (WIDTH=16, GRP_PER_STG=1, NSTG=4).
//   Expected results come from plain integer arithmetic on the operands;
//   pipeline timing comes from a simple NSTG-slot occupancy model.
//   Build with +define+CLA_PIPE_SUB_EN to also exercise subtraction.
module tb_cla_pipe_adder;

  localparam int WIDTH = 16;
  localparam int GPS   = 1;
  localparam int NSTG  = WIDTH / (4 * GPS);

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res_t expQ[$];
  bit   mValid [NSTG];

  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_pipe_adder #(
    .WIDTH       (WIDTH),
    .GRP_PER_STG (GPS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: a+b+c0 (or a-b) as plain integers, unsigned for cout and
  // signed for overflow.
  function automatic res_t refCalc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c0, input logic sub);
    res_t    r;
    longint  ua, ub, ufull, sa, sb, sres;
    ua = longint'(a);
    ub = longint'(b);
    sa = (a[WIDTH-1]) ? ua - (longint'(1) << WIDTH) : ua;
    sb = (b[WIDTH-1]) ? ub - (longint'(1) << WIDTH) : ub;
    if (sub) begin
      ufull  = ua - ub + (longint'(1) << WIDTH);
      r.cout = (ua >= ub);
      sres   = sa - sb;
    end else begin
      ufull  = ua + ub + longint'(c0);
      r.cout = (ufull >= (longint'(1) << WIDTH));
      sres   = sa + sb + longint'(c0);
    end
    r.sum = ufull[WIDTH-1:0];
    r.ovf = (sres > (longint'(1) << (WIDTH-1)) - 1) || (sres < -(longint'(1) << (WIDTH-1)));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic c0, input logic outR);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.c0        = c0;
    bus.out_ready = outR;
  endtask

  // Issue one operation into an empty pipe and wait (bounded) for its result.
  task automatic sendOne(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c0,
                         output int lat, output res_t got, output logic rdy);
    applyStimulus(1'b1, a, b, c0, 1'b1);
    #1;
    rdy = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    got.sum  = bus.sum;
    got.cout = bus.cout;
    got.ovf  = bus.ovf;
    tick();
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    rst_n = 1'b0;
    tick();
    tick();
    checks += 5;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    if (bus.sum !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sum got %h exp 0000", bus.sum); end
    if (bus.cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout got %b exp 0", bus.cout); end
    if (bus.ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b exp 0", bus.ovf); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    int lat; res_t got; logic rdy;
    sendOne(16'h1234, 16'h4321, 1'b1, lat, got, rdy);
    checks += 6;
    if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL single_in_ready got %b exp 1", rdy); end
    if (lat != NSTG) begin errors++; $display("[TB] FAIL single_latency got %0d exp %0d", lat, NSTG); end
    if (got.sum !== 16'h5556) begin errors++; $display("[TB] FAIL single_sum got %h exp 5556", got.sum); end
    if (got.cout !== 1'b0) begin errors++; $display("[TB] FAIL single_cout got %b exp 0", got.cout); end
    if (got.ovf !== 1'b0) begin errors++; $display("[TB] FAIL single_ovf got %b exp 0", got.ovf); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drained got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_carry_chain();
    int lat; res_t got; logic rdy;
    sendOne(16'hFFFF, 16'h0000, 1'b1, lat, got, rdy);
    checks += 4;
    if (lat != NSTG) begin errors++; $display("[TB] FAIL chain_latency got %0d exp %0d", lat, NSTG); end
    if (got.sum !== 16'h0000) begin errors++; $display("[TB] FAIL chain_sum got %h exp 0000", got.sum); end
    if (got.cout !== 1'b1) begin errors++; $display("[TB] FAIL chain_cout got %b exp 1", got.cout); end
    if (got.ovf !== 1'b0) begin errors++; $display("[TB] FAIL chain_ovf got %b exp 0", got.ovf); end
    sendOne(16'h7FFF, 16'h0001, 1'b0, lat, got, rdy);
    checks += 3;
    if (got.sum !== 16'h8000) begin errors++; $display("[TB] FAIL ovf_sum got %h exp 8000", got.sum); end
    if (got.cout !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cout got %b exp 0", got.cout); end
    if (got.ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_ovf got %b exp 1", got.ovf); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] opA [8];
    logic [WIDTH-1:0] opB [8];
    logic             opC [8];
    int sent = 0, got = 0, firstOut = -1, lastOut = -1;
    res_t e;
    for (int i = 0; i < 8; i++) begin
      opA[i] = WIDTH'($urandom);
      opB[i] = WIDTH'($urandom);
      opC[i] = 1'($urandom_range(0, 1));
    end
    expQ.delete();
    for (int cyc = 0; cyc < 8 + NSTG + 3; cyc++) begin
      if (sent < 8) applyStimulus(1'b1, opA[sent], opB[sent], opC[sent], 1'b1);
      else          applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready cyc %0d got %b exp 1", cyc, bus.in_ready); end
      if (bus.out_valid === 1'b1) begin
        got++;
        if (firstOut < 0) firstOut = cyc;
        lastOut = cyc;
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_extra cyc %0d got sum %h exp no result", cyc, bus.sum);
        end else begin
          e = expQ.pop_front();
          if (bus.sum !== e.sum || bus.cout !== e.cout || bus.ovf !== e.ovf) begin
            errors++;
            $display("[TB] FAIL b2b_result cyc %0d got %h/%b/%b exp %h/%b/%b",
                     cyc, bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
          end
        end
      end
      if (sent < 8) begin
        expQ.push_back(refCalc(opA[sent], opB[sent], opC[sent], 1'b0));
        sent++;
      end
      tick();
    end
    checks += 3;
    if (got != 8) begin errors++; $display("[TB] FAIL b2b_count got %0d exp 8", got); end
    if (firstOut != NSTG) begin errors++; $display("[TB] FAIL b2b_first got %0d exp %0d", firstOut, NSTG); end
    if (lastOut - firstOut != 7) begin errors++; $display("[TB] FAIL b2b_span got %0d exp 7", lastOut - firstOut); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] opA [6];
    logic [WIDTH-1:0] opB [6];
    logic             opC [6];
    int   sent = 0, delivered = 0;
    logic outR, inV, expOV, expRdy;
    for (int i = 0; i < 6; i++) begin
      opA[i] = WIDTH'($urandom);
      opB[i] = WIDTH'($urandom);
      opC[i] = 1'($urandom_range(0, 1));
    end
    expQ.delete();
    for (int k = 0; k < NSTG; k++) mValid[k] = 1'b0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      outR = !(cyc >= 4 && cyc < 7);
      inV  = (sent < 6);
      if (inV) applyStimulus(1'b1, opA[sent], opB[sent], opC[sent], outR);
      else     applyStimulus(1'b0, '0, '0, 1'b0, outR);
      #1;
      expOV  = mValid[NSTG-1];
      expRdy = !expOV || outR;
      checks += 2;
      if (bus.out_valid !== expOV) begin errors++; $display("[TB] FAIL bp_out_valid cyc %0d got %b exp %b", cyc, bus.out_valid, expOV); end
      if (bus.in_ready !== expRdy) begin errors++; $display("[TB] FAIL bp_in_ready cyc %0d got %b exp %b", cyc, bus.in_ready, expRdy); end
      if (expOV) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL bp_empty cyc %0d got sum %h exp queued result", cyc, bus.sum);
        end else if (bus.sum !== expQ[0].sum || bus.cout !== expQ[0].cout || bus.ovf !== expQ[0].ovf) begin
          errors++;
          $display("[TB] FAIL bp_result cyc %0d got %h/%b/%b exp %h/%b/%b",
                   cyc, bus.sum, bus.cout, bus.ovf, expQ[0].sum, expQ[0].cout, expQ[0].ovf);
        end
        if (outR && expQ.size() != 0) begin
          void'(expQ.pop_front());
          delivered++;
        end
      end
      if (inV && expRdy) begin
        expQ.push_back(refCalc(opA[sent], opB[sent], opC[sent], 1'b0));
        sent++;
      end
      if (expRdy) begin
        for (int k = NSTG - 1; k > 0; k--) mValid[k] = mValid[k-1];
        mValid[0] = inV;
      end
      tick();
    end
    checks += 2;
    if (delivered != 6) begin errors++; $display("[TB] FAIL bp_delivered got %0d exp 6", delivered); end
    if (expQ.size() != 0) begin errors++; $display("[TB] FAIL bp_leftover got %0d exp 0", expQ.size()); end
  endtask

  task automatic test_reset_mid();
    for (int cyc = 0; cyc < NSTG + 1; cyc++) begin
      applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre_valid got %b exp 1", bus.out_valid); end
    rst_n = 1'b0;
    tick();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out_valid got %b exp 0", bus.out_valid); end
    if (bus.sum !== 16'h0000) begin errors++; $display("[TB] FAIL rstmid_sum got %h exp 0000", bus.sum); end
    rst_n = 1'b1;
    for (int cyc = 0; cyc < NSTG + 2; cyc++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stale cyc %0d got %b exp 0", cyc, bus.out_valid); end
    end
  endtask

`ifdef CLA_PIPE_SUB_EN
  task automatic test_sub();
    int lat; res_t got; logic rdy; res_t e;
    bus.sub = 1'b1;
    sendOne(16'h0005, 16'h0007, 1'b0, lat, got, rdy);
    e = refCalc(16'h0005, 16'h0007, 1'b0, 1'b1);
    checks += 3;
    if (got.sum !== 16'hFFFE) begin errors++; $display("[TB] FAIL sub_sum got %h exp FFFE", got.sum); end
    if (got.cout !== 1'b0) begin errors++; $display("[TB] FAIL sub_cout got %b exp 0", got.cout); end
    if (got.ovf !== e.ovf) begin errors++; $display("[TB] FAIL sub_ovf got %b exp %b", got.ovf, e.ovf); end
    sendOne(16'h8000, 16'h0001, 1'b0, lat, got, rdy);
    checks += 3;
    if (got.sum !== 16'h7FFF) begin errors++; $display("[TB] FAIL subovf_sum got %h exp 7FFF", got.sum); end
    if (got.ovf !== 1'b1) begin errors++; $display("[TB] FAIL subovf_ovf got %b exp 1", got.ovf); end
    if (got.cout !== 1'b1) begin errors++; $display("[TB] FAIL subovf_cout got %b exp 1", got.cout); end
    bus.sub = 1'b0;
  endtask
`endif

  initial begin
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
`ifdef CLA_PIPE_SUB_EN
    bus.sub = 1'b0;
`endif
    test_reset();
    test_single_add();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef CLA_PIPE_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
